// File: rtl/key_evt_pkg.sv
// Shared key-event types: 2-bit key codes and the key count for the event queue.
package key_evt_pkg;

  localparam int NUM_KEYS = 4;

  typedef logic [1:0] key_code_t;

  localparam key_code_t KEY_1 = 2'd0;
  localparam key_code_t KEY_2 = 2'd1;
  localparam key_code_t KEY_3 = 2'd2;
  localparam key_code_t KEY_4 = 2'd3;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous DEPTH x 2-bit event FIFO with wrap-bit pointers.
// Provides full/empty/level; the head entry is presented combinationally from storage.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  key_code_t                 push_key,
  input  logic                      pop,
  output key_code_t                 head_key,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  key_code_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit: equal -> empty, only the wrap bit differs -> full.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_key = empty ? KEY_1 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_key;
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns active-low one-cycle key pulses into an ordered valid/ready stream of key codes.
// Optional saturating drop counter enabled by defining KEY_EVT_DROP_CNT_EN.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [4:1]               i_key_val,
  output logic                     o_evt_valid,
  output key_code_t                o_evt_key,
  input  logic                     i_evt_ready,
  output logic [$clog2(DEPTH):0]   o_evt_level,
  output logic                     o_drop,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  logic [NUM_KEYS:1] press;
  logic [NUM_KEYS:1] pending;
  logic [NUM_KEYS:1] drain;
  key_code_t         sel_code;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              lossy;

  assign press = ~i_key_val;

  // Descending scan so the lowest set pending bit wins; nothing drains while the FIFO is full.
  always_comb begin
    drain    = '0;
    sel_code = KEY_1;
    if (!fifo_full) begin
      for (int k = NUM_KEYS; k >= 1; k--) begin
        if (pending[k]) begin
          drain    = '0;
          drain[k] = 1'b1;
          sel_code = key_code_t'(k - 1);
        end
      end
    end
  end

  assign push  = |drain;
  assign pop   = o_evt_valid && i_evt_ready;
  assign lossy = |(press & pending & ~drain);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending <= '0;
      o_drop  <= 1'b0;
    end else begin
      pending <= (pending & ~drain) | press;
      if (lossy) o_drop <= 1'b1;
    end
  end

`ifdef KEY_EVT_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drop_cnt <= '0;
    else if (lossy) drop_cnt <= sat_inc(drop_cnt);
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

  key_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_key (sel_code),
    .pop      (pop),
    .head_key (o_evt_key),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (o_evt_level)
  );

  assign o_evt_valid = !fifo_empty;

endmodule
